pwm_fan_array: RTL and testbench
================================

# pwm_fan_array

Parametrised multi-channel PWM fan driver with soft-start ramping and optional phase staggering. It is the successor to the single-channel fan-speed PWM in the cooling/heating system. Each channel takes an 8-bit-class speed command from the mode/power logic and drives one fan's PWM line. A free-running period counter is shared by all channels. Duty changes are slew-limited and applied only at period boundaries, so the fans never see glitches or step loads.

## Interface
- `WIDTH`, 8: duty/counter width. PWM period is 2^WIDTH cycles.
- `CHANNELS`, 2: number of fan channels, 1..2^WIDTH.
- `STEP`, 16: maximum duty change per period boundary. 0 = jump straight to target.
- `STAGGER`, 1: 1 = channel i offset by floor(i·2^WIDTH/CHANNELS) counts; 0 = all channels in phase.
- `clk` in 1: single system clock; all state updates on rising edge.
- `arst` in 1: asynchronous, active-low reset.
- `en` in 1: global enable.
- `speed` in CHANNELS·WIDTH: target duty. Channel i is slice [i·WIDTH +: WIDTH].
- `load` in CHANNELS: per-channel strobe; captures that channel's `speed` slice into its target.
- `pwm_data` out CHANNELS: registered PWM outputs.
- `at_target` out CHANNELS: high when channel duty == target.
- `period_start` out 1: one-cycle pulse marking a period start.

## Operation
- State per block: counter `cnt` (WIDTH bits). State per channel: `target[i]` and `duty[i]` (WIDTH bits each).
- Counter:
  - `cnt <= cnt + 1` every edge, wrapping 2^WIDTH−1 → 0.
  - Counts regardless of `en`.
- Target capture:
  - On an edge with `load[i]=1`, `target[i] <= speed slice i`.
  - Otherwise `target[i]` holds.
- Boundary edge: the edge where pre-edge `cnt == 2^WIDTH−1`.
- Ramp, evaluated at boundary edges only:
  - If `duty[i] < target[i]`: `duty[i] <= duty[i] + min(STEP, target−duty)`.
  - If `duty[i] > target[i]`: `duty[i] <= duty[i] − min(STEP, duty−target)`.
  - Never overshoots. Arithmetic uses WIDTH+1 bits, so there is no wrap.
  - STEP=0: `duty[i] <= target[i]` directly.
- Phase value: `ph[i] = (cnt + off[i]) mod 2^WIDTH`.
  - `off[i] = floor(i·2^WIDTH/CHANNELS)` when STAGGER=1, else 0.
  - `off[i]` is constant at elaboration.
- Output: `pwm_data[i] <= en && (ph[i] < duty[i])`, using pre-edge values.
  - duty 0 → output never high.
  - duty 2^WIDTH−1 → high 2^WIDTH−1 of every 2^WIDTH cycles.
  - Output is never 100% high.
- `period_start <= (cnt == 2^WIDTH−1)`. It is high during the cycle in which `cnt == 0`.
- `at_target[i]` is a combinational compare of the `duty[i]` and `target[i]` registers.
- Enable low:
  - On each edge with `en=0`, `pwm_data <= 0` and `duty[i] <= 0` for all channels.
  - Targets and `cnt` are unaffected.
  - On re-enable, ramping restarts from 0 at the next boundary (soft start).
- Simultaneous events:
  - `load[i]` on a boundary edge: the ramp uses the old (pre-edge) target. The new target applies from the next boundary.
  - `en=0` takes priority over the ramp on the same edge.

## Timing
- Reset: while `arst=0`, the following are forced to 0 immediately, independent of `clk`:
  - `cnt`, all `target`, all `duty`, `pwm_data`, `period_start`.
  - Consequently `at_target` reads all-ones during reset.
- Reset mid-period: outputs drop in the same cycle. After release, the first edge gives `cnt=1` and the next period starts from a clean count.
- Latency:
  - A `load` affects `duty` at the first boundary strictly after the load edge.
  - `duty` affects `pwm_data` from the very next edge, i.e. the start of the new period.
- Ramp time: reaching target from duty d takes ceil(|target−d|/STEP) boundaries.
- Each period contains exactly `duty[i]` high cycles on each channel. Channel i's high window starts `off[i]` cycles earlier than channel 0's, modulo the period.

## Test plan
- Reset, `en=1`, WIDTH=8, STEP=16, STAGGER=0; `load[0]` with speed 64 -> duty[0] steps 16, 32, 48, 64 over 4 boundaries; `at_target[0]` rises after the 4th; then 64 high / 192 low per 256-cycle period.
- STAGGER=1, CHANNELS=2, both channels at target 64 -> ch1's high window leads ch0's by 128 cycles; both show 64 high per period; `period_start` pulses every 256 cycles.
- Targets 0 and 255 with STEP=0 -> ch0 never high; ch1 high 255 of 256 cycles from the first period after the load's boundary.
- `load` asserted on a boundary edge (pre-edge cnt=255) with new target 200 while duty=target=64 -> duty stays 64 at that boundary and moves to 80 at the next.
- Drop `en` mid-period at duty 128 -> `pwm_data` 0 from the next edge and duty becomes 0; re-raise `en` -> duty ramps 16, 32, … back to 128.
- Assert `arst` low mid-period between clock edges -> all outputs 0 immediately; after release the counter restarts at 0 and duty ramps from 0 only after a new `load`.

Source files
------------

// File: rtl/pwm_fan_array_if.sv
// pwm_fan_array_if: fan driver bus (en, speed, load in; pwm_data, at_target, period_start out)
interface pwm_fan_array_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic                      en;
  logic [CHANNELS*WIDTH-1:0] speed;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       pwm_data;
  logic [CHANNELS-1:0]       at_target;
  logic                      period_start;
  modport master (output en, speed, load, input pwm_data, at_target, period_start);
  modport slave (input en, speed, load, output pwm_data, at_target, period_start);
endinterface

// File: rtl/pwm_fan_array.sv
// pwm_fan_array: multi-channel soft-start PWM fan driver; ports clk, arst (async active-low), bus (pwm_fan_array_if.slave)
module pwm_fan_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int STEP     = 16,
  parameter int STAGGER  = 1
) (
  input logic             clk,
  input logic             arst,
  pwm_fan_array_if.slave  bus
);
  localparam int SC = (STEP >= (1 << WIDTH)) ? (1 << WIDTH) : STEP;
  localparam logic [WIDTH:0] SW = SC[WIDTH:0];
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    target [CHANNELS];
  logic [WIDTH-1:0]    duty [CHANNELS];
  logic [WIDTH-1:0]    duty_nxt [CHANNELS];
  logic [WIDTH-1:0]    ph [CHANNELS];
  logic [WIDTH:0]      up [CHANNELS];
  logic [WIDTH:0]      dn [CHANNELS];
  logic [CHANNELS-1:0] pwm_q;
  logic [CHANNELS-1:0] at;
  logic                period_q;
  logic                boundary;
  function automatic logic [WIDTH-1:0] off(input int i);
    longint o;
    o = (STAGGER != 0) ? (longint'(i) << WIDTH) / CHANNELS : 64'd0;
    return o[WIDTH-1:0];
  endfunction
  assign boundary = &cnt;
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ph[i]       = cnt + off(i);
      up[i]       = {1'b0, target[i]} - {1'b0, duty[i]};
      dn[i]       = {1'b0, duty[i]} - {1'b0, target[i]};
      duty_nxt[i] = (SC == 0) ? target[i] :
                    (duty[i] < target[i]) ? duty[i] + ((up[i] > SW) ? SW[WIDTH-1:0] : up[i][WIDTH-1:0]) :
                    duty[i] - ((dn[i] > SW) ? SW[WIDTH-1:0] : dn[i][WIDTH-1:0]);
      at[i]       = duty[i] == target[i];
    end
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt      <= '0;
      period_q <= 1'b0;
      pwm_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        duty[i]   <= '0;
      end
    end else begin
      cnt      <= cnt + 1'b1;
      period_q <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.load[i]) target[i] <= bus.speed[i*WIDTH +: WIDTH];
        duty[i]  <= !bus.en ? '0 : boundary ? duty_nxt[i] : duty[i];
        pwm_q[i] <= bus.en && (ph[i] < duty[i]);
      end
    end
  end
  assign bus.pwm_data     = pwm_q;
  assign bus.at_target    = at;
  assign bus.period_start = period_q;
endmodule

// File: tb/tb_pwm_fan_array.sv
// tb_pwm_fan_array: directed + random checks of two pwm_fan_array configurations against a behavioural model
module tb_pwm_fan_array;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic en = 1'b1;
  logic [7:0] spd [2][2];
  logic ld [2][2];
  int checks = 0;
  int failures = 0;
  int m_cnt;
  int m_tgt [2][2];
  int m_duty [2][2];
  bit m_pwm [2][2];
  bit m_ps;
  int stp [2] = '{16, 0};
  int stag [2] = '{1, 0};
  int hc [2][2];
  int fh [2][2];
  int psc;
  always #5 clk = ~clk;
  pwm_fan_array_if #(.WIDTH(8), .CHANNELS(2)) ifa ();
  pwm_fan_array_if #(.WIDTH(8), .CHANNELS(2)) ifb ();
  assign ifa.en    = en;
  assign ifa.speed = {spd[0][1], spd[0][0]};
  assign ifa.load  = {ld[0][1], ld[0][0]};
  assign ifb.en    = en;
  assign ifb.speed = {spd[1][1], spd[1][0]};
  assign ifb.load  = {ld[1][1], ld[1][0]};
  pwm_fan_array #(.WIDTH(8), .CHANNELS(2), .STEP(16), .STAGGER(1)) dut_a (.clk(clk), .arst(arst), .bus(ifa.slave));
  pwm_fan_array #(.WIDTH(8), .CHANNELS(2), .STEP(0), .STAGGER(0)) dut_b (.clk(clk), .arst(arst), .bus(ifb.slave));
  function automatic int obs_pwm(input int d, input int c);
    return (d == 0) ? int'(ifa.pwm_data[c]) : int'(ifb.pwm_data[c]);
  endfunction
  function automatic int obs_at(input int d, input int c);
    return (d == 0) ? int'(ifa.at_target[c]) : int'(ifb.at_target[c]);
  endfunction
  function automatic int obs_ps(input int d);
    return (d == 0) ? int'(ifa.period_start) : int'(ifb.period_start);
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int ramp(input int duty, input int tgt, input int step);
    int diff;
    if (step == 0) return tgt;
    diff = tgt - duty;
    if (diff > step) diff = step;
    if (diff < -step) diff = -step;
    return duty + diff;
  endfunction
  task automatic model_reset();
    m_cnt = 0;
    m_ps = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        m_tgt[d][c] = 0;
        m_duty[d][c] = 0;
        m_pwm[d][c] = 0;
      end
  endtask
  task automatic model_step();
    int off;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        off = (stag[d] != 0) ? c * 256 / 2 : 0;
        m_pwm[d][c] = en && (((m_cnt + off) % 256) < m_duty[d][c]);
        m_duty[d][c] = !en ? 0 : (m_cnt == 255) ? ramp(m_duty[d][c], m_tgt[d][c], stp[d]) : m_duty[d][c];
        if (ld[d][c]) m_tgt[d][c] = int'(spd[d][c]);
      end
    m_ps = (m_cnt == 255);
    m_cnt = (m_cnt + 1) % 256;
  endtask
  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("period_start d%0d cnt%0d", d, m_cnt), obs_ps(d), int'(m_ps));
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("pwm d%0d c%0d cnt%0d", d, c, m_cnt), obs_pwm(d, c), int'(m_pwm[d][c]));
        chk($sformatf("at_target d%0d c%0d cnt%0d", d, c, m_cnt), obs_at(d, c), int'(m_duty[d][c] == m_tgt[d][c]));
      end
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic sync(input int c);
    for (int k = 0; k < 300 && m_cnt != c; k++) cycle();
  endtask
  task automatic period();
    psc = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        hc[d][c] = 0;
        fh[d][c] = -1;
      end
    for (int k = 0; k < 256; k++) begin
      cycle();
      psc += obs_ps(0);
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++)
          if (obs_pwm(d, c) != 0) begin
            if (fh[d][c] < 0) fh[d][c] = k;
            hc[d][c]++;
          end
    end
  endtask
  task automatic async_reset();
    #2 arst = 1'b0;
    #1 model_reset();
    check_all();
    chk("reset at_target a", int'(ifa.at_target), 3);
    chk("reset at_target b", int'(ifb.at_target), 3);
    #1 arst = 1'b1;
  endtask
  initial begin
    int exp_ramp [5] = '{16, 32, 48, 64, 64};
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        spd[d][c] = 8'd0;
        ld[d][c] = 1'b0;
      end
    #1 arst = 1'b0;
    #1 model_reset();
    check_all();
    chk("reset at_target a", int'(ifa.at_target), 3);
    @(negedge clk);
    arst = 1'b1;
    spd[0][0] = 8'd64;
    spd[0][1] = 8'd64;
    spd[1][0] = 8'd0;
    spd[1][1] = 8'd255;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) ld[d][c] = 1'b1;
    cycle();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) ld[d][c] = 1'b0;
    sync(0);
    for (int p = 0; p < 5; p++) begin
      period();
      chk($sformatf("ramp a0 highs p%0d", p), hc[0][0], exp_ramp[p]);
      chk($sformatf("step0 b0 highs p%0d", p), hc[1][0], 0);
      chk($sformatf("step0 b1 highs p%0d", p), hc[1][1], 255);
      chk($sformatf("period_start count p%0d", p), psc, 1);
      if (p == 1) chk("at_target a0 before 4th boundary", int'(ifa.at_target[0]), 0);
      if (p == 2) chk("at_target a0 after 4th boundary", int'(ifa.at_target[0]), 1);
    end
    chk("stagger a1 highs", hc[0][1], 64);
    chk("stagger a0 first high", fh[0][0], 0);
    chk("stagger a1 lead", fh[0][1] - fh[0][0], 128);
    sync(255);
    spd[0][0] = 8'd200;
    ld[0][0] = 1'b1;
    cycle();
    ld[0][0] = 1'b0;
    period();
    chk("boundary load keeps old duty", hc[0][0], 64);
    period();
    chk("boundary load next step", hc[0][0], 80);
    spd[0][0] = 8'd128;
    ld[0][0] = 1'b1;
    cycle();
    ld[0][0] = 1'b0;
    sync(0);
    period();
    chk("retarget 112", hc[0][0], 112);
    period();
    chk("retarget 128", hc[0][0], 128);
    sync(100);
    chk("pre-drop pwm a0", int'(ifa.pwm_data[0]), 1);
    en = 1'b0;
    cycle();
    chk("en drop pwm a0", int'(ifa.pwm_data[0]), 0);
    sync(0);
    en = 1'b1;
    for (int p = 0; p < 9; p++) begin
      period();
      chk($sformatf("soft start a0 p%0d", p), hc[0][0], p * 16);
    end
    for (int k = 0; k < 1500; k++) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          ld[d][c] = ($urandom_range(0, 15) == 0);
          spd[d][c] = 8'($urandom);
        end
      en = ($urandom_range(0, 49) != 0);
      cycle();
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) ld[d][c] = 1'b0;
    en = 1'b1;
    spd[1][1] = 8'd255;
    ld[1][1] = 1'b1;
    cycle();
    ld[1][1] = 1'b0;
    sync(0);
    sync(60);
    chk("pre-reset pwm b1", int'(ifb.pwm_data[1]), 1);
    async_reset();
    period();
    chk("post-reset a0 idle", hc[0][0], 0);
    chk("post-reset b1 idle", hc[1][1], 0);
    chk("post-reset period_start count", psc, 1);
    chk("post-reset period_start at cnt0", int'(ifa.period_start), 1);
    spd[0][0] = 8'd64;
    ld[0][0] = 1'b1;
    cycle();
    ld[0][0] = 1'b0;
    sync(0);
    period();
    chk("post-reset ramp a0", hc[0][0], 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
